branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with per-entry saturating direction counters, parametrised in entry count and counter width.
- Lookup is combinational and serves the fetch stage: the datapath steers the PC to the predicted target the same cycle.
- Update comes from the execute stage when a branch or jump resolves.
- The block flags mispredicts and supplies the corrected PC, so the hazard unit flushes IF/ID and ID/EX only on a wrong prediction, not on every taken branch.

Parameters:
ENTRIES, 16, number of BTB entries; power of 2, range 2..256; IDX = log2(ENTRIES)
CTR_BITS, 2, saturating counter width, range 1..4; predict taken when counter MSB = 1
TAG_BITS, 30-IDX, tag width; tag = pc[31:IDX+2]

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous reset, active-high (1 = reset)
lk_pc  in  32  fetch-stage PC
pred_taken  out  1  predicted taken for lk_pc
pred_target  out  32  predicted target; lk_pc+4 when pred_taken=0
upd_en  in  1  one resolved control-transfer instruction this cycle (pipeline not stalled)
upd_pc  in  32  PC of the resolving instruction
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_pred_taken  in  1  prediction carried down the pipeline with the instruction
upd_pred_target  in  32  predicted target carried down the pipeline
mispredict  out  1  prediction was wrong; flush younger stages
correct_pc  out  32  upd_taken ? upd_target : upd_pc+4
inv_all  in  1  synchronous invalidate of all entries

Behaviour:
- Entry state: valid bit, tag, 32-bit target, CTR_BITS counter. Index = pc[IDX+1:2]; pc[1:0] ignored.
- Lookup (combinational):
  - hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[CTR_BITS-1].
  - pred_target = pred_taken ? target : lk_pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- mispredict (combinational, gated by upd_en):
  - mispredict = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - correct_pc is valid whenever upd_en=1.
- Update (rising edge, upd_en=1):
  - Hit, taken: counter increments, saturating at 2^CTR_BITS-1; target <= upd_target.
  - Hit, not taken: counter decrements, saturating at 0; the entry stays valid.
  - Miss, taken: allocate, replacing any occupant. valid=1, tag set, target=upd_target, counter=2^(CTR_BITS-1), which is weakly taken.
  - Miss, not taken: no state change.
- Read-old semantics:
  - Lookup and update to the same index in one cycle: lookup sees pre-update state.
  - The update is visible to lookups from the next cycle.
- inv_all:
  - Clears all valid bits at the next edge. Counters and targets are don't-care.
  - inv_all and upd_en in the same cycle: inv_all wins; the update is dropped.
- Reset (nRST=1, asynchronous):
  - All valid bits = 0; counters = 2^(CTR_BITS-1)-1, which is weakly not-taken.
  - Hence pred_taken=0 and pred_target=lk_pc+4 immediately.
  - mispredict follows its inputs combinationally.
  - Reset mid-operation discards all state. No partial update completes on the edge where reset deasserts.
- CTR_BITS=1 degenerates to last-outcome prediction: counter is 1 = taken, 0 = not taken; allocation sets 1.

Optional Feature:
- BP_STATS_EN defined: adds outputs stat_lookups[31:0], stat_updates[31:0] and stat_mispredicts[31:0].
  - Free-running counters, reset to 0, wrapping at 2^32.
  - stat_lookups increments on every cycle nRST=0.
  - stat_updates increments on upd_en.
  - stat_mispredicts increments when mispredict=1.
  - inv_all does not clear them.
- BP_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then lk_pc=0x40: pred_taken=0, pred_target=0x44. Hold nRST=1 mid-run after training: predictions return to not-taken in the same cycle.
- upd_en, upd_pc=0x40, taken, target=0x100, pred_taken=0: mispredict=1, correct_pc=0x100. Next cycle, lk_pc=0x40 gives pred_taken=1, pred_target=0x100.
- Train 0x40 taken 3 more times (counter saturates at 3), then 2 not-taken updates: still taken after the first (counter 2), not-taken after the second (counter 1). A third not-taken update with pred_taken=0 gives mispredict=0.
- Conflict: allocate 0x40 (tag 1), then allocate 0x80 (tag 2, same index 0) taken to 0x200. lk_pc=0x40 misses (0x44); lk_pc=0x80 predicts 0x200.
- Same-cycle: lk_pc=0x40 with a taken update to 0x40 on an empty BTB: pred_taken=0 that cycle, 1 the next. inv_all together with upd_en: the entry is not allocated.
- Target change: 0x40 hit, predicted 0x100, actual taken to 0x180: mispredict=1, correct_pc=0x180, next lookup gives 0x180. With BP_STATS_EN, stat_mispredicts increments by exactly 1.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup for fetch, edge-triggered update from execute, and
// combinational mispredict / corrected-PC generation for the hazard unit.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lk_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  input  logic        inv_all
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX      = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = 30 - IDX;

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];
  logic [CTR_BITS-1:0] ctr_mem    [ENTRIES];

  logic [IDX-1:0]      l_idx;
  logic [TAG_BITS-1:0] l_tag;
  logic                l_hit;
  logic [IDX-1:0]      u_idx;
  logic [TAG_BITS-1:0] u_tag;
  logic                u_hit;
  logic [CTR_BITS-1:0] u_ctr;
  logic                unused_pc_bits;

  assign l_idx = lk_pc[IDX+1:2];
  assign l_tag = lk_pc[31:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[31:IDX+2];
  assign u_ctr = ctr_mem[u_idx];

  // Byte offset within the instruction word plays no part in indexing.
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  // Fetch-side lookup; reads pre-update state of the arrays.
  always_comb begin
    l_hit       = valid[l_idx] && (tag_mem[l_idx] == l_tag);
    pred_taken  = l_hit && ctr_mem[l_idx][CTR_BITS-1];
    pred_target = pred_taken ? target_mem[l_idx] : lk_pc + 32'd4;
  end

  // Execute-side resolution: wrong direction, or taken to a different target.
  always_comb begin
    u_hit      = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end

  // Valid bits and direction counters; invalidate beats a same-cycle update.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_mem[i] <= CTR_WNT;
    end else if (inv_all) begin
      valid <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (u_ctr != CTR_MAX) ctr_mem[u_idx] <= u_ctr + 1'b1;
        end else begin
          if (u_ctr != '0) ctr_mem[u_idx] <= u_ctr - 1'b1;
        end
      end else if (upd_taken) begin
        valid[u_idx]   <= 1'b1;
        ctr_mem[u_idx] <= CTR_WT;
      end
    end
  end

  // Tag and target payload; only meaningful behind a valid bit, so no reset.
  always_ff @(posedge CLK) begin
    if (!nRST && !inv_all && upd_en && upd_taken) begin
      tag_mem[u_idx]    <= u_tag;
      target_mem[u_idx] <= upd_target;
    end
  end

`ifdef BP_STATS_EN
  // Free-running activity counters, untouched by inv_all.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      stat_lookups     <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      if (upd_en)     stat_updates     <= stat_updates + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each step drives one cycle of
// lookup/update stimulus, queues its expected outputs and checks them.
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic        inv_all;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int vectors     = 0;
  int miscompares = 0;

  int exp_lk  = 0;
  int exp_up  = 0;
  int exp_mis = 0;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] cpc;
    logic        chk_cpc;
  } exp_t;

  exp_t sbq[$];

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .lk_pc           (lk_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_en          (upd_en),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .correct_pc      (correct_pc),
    .inv_all         (inv_all)
`ifdef BP_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, queue expectations, compare before the posedge.
  task automatic step(input string name, input logic rst, input logic [31:0] lk,
                      input logic ue, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                      input logic inv, input logic e_pt, input logic [31:0] e_ptgt,
                      input logic e_mp, input logic [31:0] e_cpc);
    exp_t e;
    @(negedge CLK);
    nRST            = rst;
    lk_pc           = lk;
    upd_en          = ue;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    inv_all         = inv;
    e.name = name; e.pt = e_pt; e.ptgt = e_ptgt; e.mp = e_mp; e.cpc = e_cpc; e.chk_cpc = ue;
    sbq.push_back(e);
    #2;
    e = sbq.pop_front();
    check({e.name, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, e.pt});
    check({e.name, ".pred_target"}, pred_target, e.ptgt);
    check({e.name, ".mispredict"},  {31'd0, mispredict}, {31'd0, e.mp});
    if (e.chk_cpc) check({e.name, ".correct_pc"}, correct_pc, e.cpc);
`ifdef BP_STATS_EN
    check({e.name, ".stat_lookups"},     stat_lookups,     32'(exp_lk));
    check({e.name, ".stat_updates"},     stat_updates,     32'(exp_up));
    check({e.name, ".stat_mispredicts"}, stat_mispredicts, 32'(exp_mis));
`endif
    if (rst) begin
      exp_lk = 0; exp_up = 0; exp_mis = 0;
    end else begin
      exp_lk++;
      if (ue)   exp_up++;
      if (e_mp) exp_mis++;
    end
  endtask

  task automatic idle(input string name, input logic [31:0] lk, input logic e_pt,
                      input logic [31:0] e_ptgt);
    step(name, 1'b0, lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, e_pt, e_ptgt, 1'b0, 32'h4);
  endtask

  initial begin
    nRST = 1'b1; lk_pc = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; inv_all = 1'b0;

    // Reset: no prediction, mispredict still combinational, no allocation.
    step("rst_hold", 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b1, 32'h100);
    idle("rst_release", 32'h40, 1'b0, 32'h44);

    // First taken resolution allocates; same-cycle lookup still sees empty BTB.
    step("alloc", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b1, 32'h100);
    // Counter 2 -> 3 -> 3 -> 3 (saturating).
    step("train1", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0,
         1'b1, 32'h100, 1'b0, 32'h100);
    step("train2", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0,
         1'b1, 32'h100, 1'b0, 32'h100);
    step("train3", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0,
         1'b1, 32'h100, 1'b0, 32'h100);
    // Not-taken: 3 -> 2 -> 1 -> 0.
    step("nt1", 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0,
         1'b1, 32'h100, 1'b1, 32'h44);
    step("nt2", 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0,
         1'b1, 32'h100, 1'b1, 32'h44);
    step("nt3", 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b0, 32'h44);
    // Entry stays valid at counter 0: taken hits increment 0 -> 1 -> 2.
    step("reinc1", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b1, 32'h100);
    step("reinc2", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b1, 32'h100);
    // Right direction, wrong target.
    step("tgt_change", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b0,
         1'b1, 32'h100, 1'b1, 32'h180);
    // Conflicting allocation at index 0 with a different tag.
    step("conflict", 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0,
         1'b1, 32'h180, 1'b1, 32'h200);
    idle("evicted", 32'h40, 1'b0, 32'h44);
    idle("new_occupant", 32'h80, 1'b1, 32'h200);
    idle("other_index", 32'h44, 1'b0, 32'h48);

    // Invalidate wins over a same-cycle allocation.
    step("inv_upd", 1'b0, 32'h80, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1,
         1'b1, 32'h200, 1'b1, 32'h100);
    idle("inv_80", 32'h80, 1'b0, 32'h84);
    idle("inv_40", 32'h40, 1'b0, 32'h44);

    // Wrap of the fall-through PC and upd_en gating of mispredict.
    idle("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    step("gated", 1'b0, 32'h40, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b0, 32'h0);

    // Retrain, then reset asynchronously in the middle of a cycle.
    step("retrain", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b1, 32'h100);
    idle("retrained", 32'h40, 1'b1, 32'h100);
    #1 nRST = 1'b1;
    #1;
    check("async_rst.pred_taken",  {31'd0, pred_taken}, 32'h0);
    check("async_rst.pred_target", pred_target, 32'h44);
    exp_lk = 0; exp_up = 0; exp_mis = 0;
    step("rst_upd", 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
         1'b0, 32'h44, 1'b1, 32'h100);
    idle("post_rst1", 32'h40, 1'b0, 32'h44);
    idle("post_rst2", 32'h40, 1'b0, 32'h44);

    @(negedge CLK);
`ifdef BP_STATS_EN
    check("final.stat_lookups",     stat_lookups,     32'(exp_lk));
    check("final.stat_updates",     stat_updates,     32'(exp_up));
    check("final.stat_mispredicts", stat_mispredicts, 32'(exp_mis));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
